// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the RV32I instruction encoder.
// The encoder sits on the slave modport; the field producer and word consumer use master.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_invalid;
  logic        err_range;
  logic [15:0] enc_count;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, err_invalid, err_range, enc_count
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, err_invalid, err_range, enc_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and queues them in a small FIFO.
// Optional immediate range checking is enabled with `define INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] K_LUI    = 4'd0;
  localparam logic [3:0] K_AUIPC  = 4'd1;
  localparam logic [3:0] K_JAL    = 4'd2;
  localparam logic [3:0] K_JALR   = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_LOAD   = 4'd5;
  localparam logic [3:0] K_STORE  = 4'd6;
  localparam logic [3:0] K_ALUI   = 4'd7;
  localparam logic [3:0] K_ALUR   = 4'd8;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  function automatic logic is_shift(input logic [3:0] kind, input logic [2:0] f3);
    return (kind == K_ALUI) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      K_LUI:    w = {imm[31:12], rd, OP_LUI};
      K_AUIPC:  w = {imm[31:12], rd, OP_AUIPC};
      K_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      // JALR has only one legal funct3, so the supplied one is ignored
      K_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      K_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      K_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      K_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      K_ALUI: begin
        if (is_shift(kind, f3))
          w = {f7, imm[4:0], rs1, f3, rd, OP_ALUI};
        else
          w = {imm[11:0], rs1, f3, rd, OP_ALUI};
      end
      K_ALUR:   w = {f7, rs2, rs1, f3, rd, OP_ALUR};
      default:  w = '0;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  function automatic logic imm_in_range(
    input logic [3:0]         kind,
    input logic [2:0]         f3,
    input logic signed [31:0] imm
  );
    logic ok;
    logic i_ok;
    i_ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
    ok   = 1'b1;
    case (kind)
      K_LUI, K_AUIPC:          ok = (imm[11:0] == 12'd0);
      K_JAL:                   ok = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      K_BRANCH:                ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      K_JALR, K_LOAD, K_STORE: ok = i_ok;
      K_ALUI: begin
        if (is_shift(kind, f3))
          ok = (imm >= 32'sd0) && (imm <= 32'sd31);
        else
          ok = i_ok;
      end
      default:                 ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  // Registered control state
  logic [CNT_W-1:0] count_p1;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic             in_ready_p1;
  logic             vld_p1;
  logic             err_invalid_p1;
  logic [15:0]      enc_count_p1;
  logic [31:0]      mem_p1 [DEPTH];

  // Stage p0: accept, encode and classify the offered bundle
  logic             vld_p0;
  logic             kind_ok_p0;
  logic             range_ok_p0;
  logic             push_p0;
  logic             pop_p0;
  logic [31:0]      word_p0;
  logic [CNT_W-1:0] count_nx;

  always_comb begin
    vld_p0     = bus.in_valid && in_ready_p1;
    kind_ok_p0 = (bus.in_kind <= K_ALUR);
    word_p0    = encode(bus.in_kind, bus.in_rd, bus.in_rs1, bus.in_rs2,
                        bus.in_funct3, bus.in_funct7, bus.in_imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    range_ok_p0 = imm_in_range(bus.in_kind, bus.in_funct3, $signed(bus.in_imm));
`else
    range_ok_p0 = 1'b1;
`endif
    push_p0 = vld_p0 && kind_ok_p0 && range_ok_p0;
    pop_p0  = vld_p1 && bus.out_ready;

    count_nx = count_p1;
    case ({push_p0, pop_p0})
      2'b10:   count_nx = count_p1 + CNT_W'(1);
      2'b01:   count_nx = count_p1 - CNT_W'(1);
      default: count_nx = count_p1;
    endcase
  end

  // Stage p1: FIFO storage and registered status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1       <= '0;
      wr_ptr_p1      <= '0;
      rd_ptr_p1      <= '0;
      in_ready_p1    <= 1'b1;
      vld_p1         <= 1'b0;
      err_invalid_p1 <= 1'b0;
      enc_count_p1   <= '0;
    end else begin
      count_p1       <= count_nx;
      in_ready_p1    <= (count_nx != CNT_W'(DEPTH));
      vld_p1         <= (count_nx != '0);
      err_invalid_p1 <= vld_p0 && !kind_ok_p0;
      if (push_p0) begin
        wr_ptr_p1    <= wr_ptr_p1 + PTR_W'(1);
        enc_count_p1 <= enc_count_p1 + 16'd1;
      end
      if (pop_p0)
        rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0)
      mem_p1[wr_ptr_p1] <= word_p0;
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic err_range_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_range_p1 <= 1'b0;
    else
      err_range_p1 <= vld_p0 && kind_ok_p0 && !range_ok_p0;
  end

  assign bus.err_range = err_range_p1;
`else
  assign bus.err_range = 1'b0;
`endif

  assign bus.in_ready    = in_ready_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_instr   = mem_p1[rd_ptr_p1];
  assign bus.err_invalid = err_invalid_p1;
  assign bus.enc_count   = enc_count_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based reference model checked every cycle,
// plus hand-computed instruction words for known RV32I encodings.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference encoder built from bit arithmetic on the instruction format tables
  function automatic logic [31:0] model_enc(input logic [31:0] k, rd, rs1, rs2, f3, f7, imm);
    logic [31:0] op;
    logic [31:0] w;
    case (k)
      0: op = 32'h37; 1: op = 32'h17; 2: op = 32'h6F; 3: op = 32'h67; 4: op = 32'h63;
      5: op = 32'h03; 6: op = 32'h23; 7: op = 32'h13; default: op = 32'h33;
    endcase
    case (k)
      0, 1: w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
      2: w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      3: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | op;
      4: w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | op;
      6: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
      7: if (f3 == 1 || f3 == 5)
           w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         else
           w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      8: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endcase
    return w;
  endfunction

  function automatic logic model_bad(input logic [31:0] k, f3, imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    int v;
    v = $signed(imm);
    case (k)
      0, 1: return (imm & 32'hFFF) != 0;
      2: return v < -1048576 || v > 1048574 || imm[0];
      4: return v < -4096 || v > 4094 || imm[0];
      7: if (f3 == 1 || f3 == 5) return v < 0 || v > 31;
         else return v < -2048 || v > 2047;
      3, 5, 6: return v < -2048 || v > 2047;
      default: return 1'b0;
    endcase
`else
    return (k == 32'hFFFF_FFFF) && (f3 == imm) && 1'b0;
`endif
  endfunction

  logic [31:0] m_q[$];
  logic [15:0] m_cnt;
  logic        m_ei;
  logic        m_er;
  logic        started;

  initial started = 1'b0;

  always @(posedge clk) begin : model
    int   sz;
    logic acc, push, pop, kok;
    started = 1'b1;
    if (!rst_n) begin
      m_q.delete();
      m_cnt = '0;
      m_ei  = 1'b0;
      m_er  = 1'b0;
    end else begin
      sz   = m_q.size();
      acc  = bus.in_valid && (sz != DEPTH);
      pop  = (sz != 0) && bus.out_ready;
      kok  = (bus.in_kind <= 4'd8);
      m_ei = acc && !kok;
      m_er = acc && kok && model_bad(32'(bus.in_kind), 32'(bus.in_funct3), bus.in_imm);
      push = acc && kok && !m_er;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(model_enc(32'(bus.in_kind), 32'(bus.in_rd), 32'(bus.in_rs1),
                                32'(bus.in_rs2), 32'(bus.in_funct3), 32'(bus.in_funct7),
                                bus.in_imm));
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(bus.in_ready), 32'(m_q.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_instr", bus.out_instr, m_q[0]);
      check("enc_count", 32'(bus.enc_count), 32'(m_cnt));
      check("err_invalid", 32'(bus.err_invalid), 32'(m_ei));
      check("err_range", 32'(bus.err_range), 32'(m_er));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int n;
    bus.in_valid = 1'b1; bus.in_kind = k; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_ready", 32'(bus.in_ready), 32'd1);
    else @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one(input string name, input logic [31:0] exp);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(name, bus.out_instr, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_empty", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_kind = '0; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_enc_count", 32'(bus.enc_count), 32'd0);
    check("rst_err_invalid", 32'(bus.err_invalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("addi_count", 32'(bus.enc_count), 32'd1);
    pop_one("addi", 32'h0050_0093);
    check("model_addi", model_enc(7, 1, 0, 0, 0, 0, 5), 32'h0050_0093);

    send(4'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(4'd8, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    pop_one("lui", 32'h1234_52B7);
    pop_one("add", 32'h0020_81B3);

    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    pop_one("beq", 32'hFE20_8EE3);
    send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    pop_one("jal", 32'h0080_00EF);
    send(4'd6, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -32'sd8);
    pop_one("sw", 32'hFE31_2C23);
    send(4'd3, 5'd0, 5'd1, 5'd0, 3'd5, 7'd0, 32'd0);
    pop_one("jalr", 32'h0000_8067);
    send(4'd7, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3);
    pop_one("srai", 32'h4030_D093);
    check("count8", 32'(bus.enc_count), 32'd8);

    send(4'd5, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'd2047);
    send(4'd1, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);
    drain();

    for (int i = 0; i < DEPTH; i++)
      send(4'd7, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3));
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_kind = 4'd7; bus.in_rd = 5'd9; bus.in_imm = 32'd9;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("pop_in_ready", 32'(bus.in_ready), 32'd1);
    check("fifth_dropped", 32'(bus.enc_count), 32'd14);
    pop_one("fifo_head", 32'h0030_0113);
    drain();

    send(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd1);
    check("inv_pulse", 32'(bus.err_invalid), 32'd1);
    check("inv_count", 32'(bus.enc_count), 32'd14);
    check("inv_nopush", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("inv_clear", 32'(bus.err_invalid), 32'd0);

    send(4'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("rng_pulse", 32'(bus.err_range), 32'd1);
    check("rng_nopush", 32'(bus.out_valid), 32'd0);
    check("rng_count", 32'(bus.enc_count), 32'd14);
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576);
    drain();
`else
    check("trunc_count", 32'(bus.enc_count), 32'd15);
    pop_one("trunc", 32'h0000_0013);
`endif

    for (int i = 0; i < 3; i++)
      send(4'd8, 5'(i), 5'd1, 5'd2, 3'(i), 7'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_count", 32'(bus.enc_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("post_rst_count", 32'(bus.enc_count), 32'd1);
    pop_one("post_rst", 32'h0050_0093);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles RV32I instruction words from decoded fields: the inverse of the core's instruction decode stage. It accepts one field bundle per valid/ready transfer, packs it into a 32-bit word using the standard R/I/S/B/U/J layouts, and buffers results in a small FIFO for the instruction-memory loader or self-test sequencer. It also keeps a running count of emitted words.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  field bundle present.
- `in_ready`  out  1  encoder can accept; equals `count != DEPTH`.
- `in_kind`  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ALUI, 8 ALUR; 9–15 invalid.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register addresses.
- `in_funct3`  in  3; `in_funct7`  in  7.
- `in_imm`  in  32  signed byte offset or immediate value.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer takes head word.
- `out_instr`  out  32  FIFO head word.
- `err_invalid`  out  1  one-cycle pulse: invalid kind accepted and dropped.
- `err_range`  out  1  one-cycle pulse: immediate out of range (see Configuration).
- `enc_count`  out  16  words pushed since reset; wraps from 0xFFFF to 0.

## Operation
- Accept when `in_valid && in_ready`. Encode combinationally and push in the same edge.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALUI 0010011, ALUR 0110011.
- R (ALUR): `{funct7, rs2, rs1, funct3, rd, op}`.
- I (JALR, LOAD, ALUI): `{imm[11:0], rs1, funct3, rd, op}`. For JALR, funct3 is forced to 000.
- ALUI shifts (funct3 001/101): `{funct7, imm[4:0], rs1, funct3, rd, op}`.
- S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], op}`.
- B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}`.
- U: `{imm[31:12], rd, op}`.
- J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, op}`.
- Fields unused by a format are ignored.
- Invalid kind: the transfer is accepted, nothing is pushed, `err_invalid` pulses, and `enc_count` is unchanged.
- FIFO: a pop occurs on `out_valid && out_ready`, and pointers wrap modulo DEPTH.
- Simultaneous push and pop: `count` is unchanged.
- When full, `in_ready` is 0 even if a pop occurs that cycle. There is no combinational path from `out_ready` to `in_ready`.
- Empty: `out_valid` is 0 and the `out_instr` value is don't-care (bench must not check it).

## Timing
- Latency: a word accepted at edge N drives `out_valid=1` and `out_instr` immediately after edge N.
- `in_ready` and `out_valid` are registered from `count`.
- `err_*` are registered and high for exactly the cycle after the offending accept.
- Reset (any cycle, including mid-stream) sets:
  - `count=0`, pointers 0, `out_valid=0`, `in_ready=1`;
  - `err_invalid=0`, `err_range=0`, `enc_count=0`.
- Buffered words are discarded on reset.
- `enc_count` increments once per successful push.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined:
  - I/S range is −2048..2047; shift range is 0..31.
  - B range is −4096..4094, even; J range is −1048576..1048574, even.
  - U requires `imm[11:0]==0`.
  - A violation is accepted but not pushed: `err_range` pulses and `enc_count` is unchanged.
- Undefined: immediates are truncated to the encoded bits without checking, and `err_range` is tied 0.

## Test plan
- ALUI `rd=1 rs1=0 f3=0 imm=5` → `out_instr=0x00500093` one cycle later, `enc_count=1`.
- LUI `rd=5 imm=0x12345000`, then ALUR `rd=3 rs1=1 rs2=2 f3=0 f7=0` → `0x123452B7`, then `0x002081B3`, in order.
- BRANCH `rs1=1 rs2=2 f3=0 imm=-4` → `0xFE208EE3`; JAL `rd=1 imm=8` → `0x008000EF`.
- Hold `out_ready=0` and offer 5 words → 4 accepted, `in_ready=0`. Assert `out_ready` for one cycle → `in_ready` returns 1 next cycle. Drain → words in FIFO order, `out_valid=0`.
- Kind 12 → `err_invalid` pulse, no push. With the macro, ALUI `imm=4096` → `err_range` pulse, no push; without it, the word is `0x00000013`-style with `imm[11:0]=0`.
- Reset asserted with 3 words buffered → next cycle `out_valid=0`, `in_ready=1`, `enc_count=0`.
